intctrl: RTL and testbench

INTCTRL -- requirements
Module: intctrl

---
 rtl/intctrl_pkg.sv | 23 ++
 rtl/intctrl_rrsel.sv | 36 +++
 rtl/intctrl.sv | 182 ++++++++++++++++++
 tb/tb_intctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intctrl_pkg.sv
// Shared pi1 slave encodings, command word layout and intctrl FSM state constants.
package intctrl_pkg;

    typedef enum logic [1:0] {
        PI1_NOOP = 2'd0,
        PI1_WR   = 2'd1,
        PI1_RD   = 2'd2,
        PI1_RW   = 2'd3
    } pi1_op_e;

    // Command word: bit 0 selects ACK (1) or TRIGGER (0); the argument sits above it.
    localparam int CMD_ACK_BIT = 0;
    localparam int CMD_ARG_LSB = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEEK = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;

    function automatic int idxBits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intctrl_rrsel.sv
// Round-robin selector: first set bit of i_mask at or after i_start, wrapping past N-1 to 0.
module intctrl_rrsel
    import intctrl_pkg::*;
#(
    parameter int N = 2,
    parameter int W = idxBits(N)
) (
    input  logic [N-1:0] i_mask,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_index,
    output logic         o_found
);

    logic [N-1:0] w_rot;
    logic [W:0]   w_sum;

    // Rotating the doubled mask puts the search start at bit 0.
    assign w_rot = N'({i_mask, i_mask} >> i_start);

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = (W+1)'(i_start) + (W+1)'(k);
                if (w_sum >= (W+1)'(N)) begin
                    w_sum = w_sum - (W+1)'(N);
                end
                o_index = w_sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/intctrl.sv
// Interrupt controller: latches source edges as pending and hands each one to a ready PU,
// round-robin, with acceptance/timeout handshake and a pi1 command register for ACK/TRIGGER.
module intctrl
    import intctrl_pkg::*;
#(
    parameter int SRCCOUNT   = 2,
    parameter int DSTCOUNT   = 2,
    parameter int ARCHBITSZ  = 32,
    parameter int ACKTIMEOUT = 64,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    input  logic [SRCCOUNT-1:0]    intsrc_i,
    output logic [DSTCOUNT-1:0]    intrqst_o,
    input  logic [DSTCOUNT-1:0]    intrdy_i
);

    localparam int SRCW = idxBits(SRCCOUNT);
    localparam int DSTW = idxBits(DSTCOUNT);
    localparam int TMW  = idxBits(ACKTIMEOUT);

    logic [SRCCOUNT-1:0]  r_srcPrev;
    logic [SRCCOUNT-1:0]  r_pending;
    logic [1:0]           r_state;
    logic [SRCW-1:0]      r_curSrc;
    logic [DSTW-1:0]      r_curDst;
    logic [DSTW-1:0]      r_rrPtr;
    logic [TMW-1:0]       r_timer;
    logic [DSTCOUNT-1:0]  r_intrqst;
    logic [SRCW-1:0]      r_ackId [DSTCOUNT];
    logic [DSTCOUNT-1:0]  r_ackValid;
    logic [ARCHBITSZ-1:0] r_data;

    logic [ARCHBITSZ-2:0] w_cmdArg;
    logic                 w_isAck;
    logic                 w_isTrig;
    logic                 w_argDstOk;
    logic                 w_argSrcOk;
    logic [DSTW-1:0]      w_argDst;
    logic [SRCW-1:0]      w_argSrc;
    logic                 w_accept;
    logic                 w_timeout;
    logic [SRCCOUNT-1:0]  w_edge;
    logic [SRCCOUNT-1:0]  w_trigMask;
    logic [SRCCOUNT-1:0]  w_clrMask;
    logic [SRCW-1:0]      w_lowSrc;
    logic [DSTW-1:0]      w_nextPtr;
    logic [DSTW-1:0]      w_selIdx;
    logic                 w_selFound;
    logic [ARCHBITSZ-1:0] w_result;
    logic                 w_unused;

    assign w_unused   = ^{pi1_addr_i, pi1_sel_i};
    assign pi1_rdy_o  = 1'b1;
    assign pi1_data_o = r_data;
    assign intrqst_o  = r_intrqst;

    assign w_cmdArg   = pi1_data_i[ARCHBITSZ-1:CMD_ARG_LSB];
    assign w_isAck    = (pi1_op_i == PI1_RW) && pi1_data_i[CMD_ACK_BIT];
    assign w_isTrig   = (pi1_op_i == PI1_RW) && !pi1_data_i[CMD_ACK_BIT];
    assign w_argDstOk = w_cmdArg < (ARCHBITSZ-1)'(DSTCOUNT);
    assign w_argSrcOk = w_cmdArg < (ARCHBITSZ-1)'(SRCCOUNT);
    assign w_argDst   = w_cmdArg[DSTW-1:0];
    assign w_argSrc   = w_cmdArg[SRCW-1:0];

    // A PU takes the request by dropping its ready line while it is being asked.
    assign w_accept   = (r_state == ST_REQ) && !intrdy_i[r_curDst];
    assign w_timeout  = (r_state == ST_REQ) && !w_accept && (r_timer == TMW'(ACKTIMEOUT-1));
    assign w_nextPtr  = (r_curDst == DSTW'(DSTCOUNT-1)) ? '0 : r_curDst + 1'b1;

    assign w_edge     = intsrc_i & ~r_srcPrev;
    assign w_trigMask = (w_isTrig && w_argSrcOk) ? (SRCCOUNT'(1) << w_argSrc) : '0;
    assign w_clrMask  = w_accept ? (SRCCOUNT'(1) << r_curSrc) : '0;

    always_comb begin
        w_lowSrc = '0;
        for (int i = SRCCOUNT-1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lowSrc = SRCW'(i);
            end
        end
    end

    always_comb begin
        w_result = '1;
        if (w_isAck && w_argDstOk && r_ackValid[w_argDst]) begin
            w_result = ARCHBITSZ'(r_ackId[w_argDst]);
        end else if (w_isTrig && w_argSrcOk) begin
            w_result = ARCHBITSZ'(w_argSrc);
        end
    end

    intctrl_rrsel #(
        .N(DSTCOUNT),
        .W(DSTW)
    ) u_rrsel (
        .i_mask (intrdy_i),
        .i_start(r_rrPtr),
        .o_index(w_selIdx),
        .o_found(w_selFound)
    );

    // New edges are OR-ed in after the clear so a re-trigger during acceptance survives.
    always_ff @(posedge clk_i) begin
        r_srcPrev <= intsrc_i;
        if (rst_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clrMask) | w_edge | w_trigMask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_curSrc  <= '0;
            r_curDst  <= '0;
            r_rrPtr   <= '0;
            r_timer   <= '0;
            r_intrqst <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_curSrc <= w_lowSrc;
                        r_state  <= ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    if (w_selFound) begin
                        r_curDst  <= w_selIdx;
                        r_intrqst <= DSTCOUNT'(1) << w_selIdx;
                        r_timer   <= '0;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_accept || w_timeout) begin
                        r_intrqst <= '0;
                        r_rrPtr   <= w_nextPtr;
                        r_state   <= w_accept ? ST_IDLE : ST_SEEK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The accept write comes last so a same-cycle ACK reads the old id but the new one is kept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ackValid <= '0;
            r_data     <= '1;
        end else begin
            if (pi1_op_i != PI1_NOOP) begin
                r_data <= w_result;
            end
            if (w_isAck && w_argDstOk) begin
                r_ackValid[w_argDst] <= 1'b0;
            end
            if (w_accept) begin
                r_ackValid[r_curDst] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept && !rst_i) begin
            r_ackId[r_curDst] <= r_curSrc;
        end
    end

endmodule

// File: tb/tb_intctrl.sv
// Scoreboard bench for intctrl: drivers queue expected pi1 results and PU targets,
// monitors pop and compare whenever a response or a new request appears.
module tb_intctrl;

    localparam int SRCCOUNT   = 4;
    localparam int DSTCOUNT   = 2;
    localparam int ARCHBITSZ  = 32;
    localparam int ACKTIMEOUT = 16;
    localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ/8);
    localparam logic [ARCHBITSZ-1:0] ALLONES = '1;
    localparam logic [1:0] OP_NOOP = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;
    localparam logic [1:0] OP_RW   = 2'd3;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [1:0]             pi1_op_i;
    logic [ADDRBITSZ-1:0]   pi1_addr_i;
    logic [ARCHBITSZ-1:0]   pi1_data_i;
    logic [ARCHBITSZ-1:0]   pi1_data_o;
    logic [ARCHBITSZ/8-1:0] pi1_sel_i;
    logic                   pi1_rdy_o;
    logic [SRCCOUNT-1:0]    intsrc_i;
    logic [DSTCOUNT-1:0]    intrqst_o;
    logic [DSTCOUNT-1:0]    intrdy_i;

    int testsRun = 0;
    int testsFailed = 0;
    logic [ARCHBITSZ-1:0] qResp[$];
    int qDeliv[$];
    int modelRr = 0;
    logic opSeen = 1'b0;
    logic [DSTCOUNT-1:0] prevReq = '0;

    intctrl #(
        .SRCCOUNT  (SRCCOUNT),
        .DSTCOUNT  (DSTCOUNT),
        .ARCHBITSZ (ARCHBITSZ),
        .ACKTIMEOUT(ACKTIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pi1_op_i  (pi1_op_i),
        .pi1_addr_i(pi1_addr_i),
        .pi1_data_i(pi1_data_i),
        .pi1_data_o(pi1_data_o),
        .pi1_sel_i (pi1_sel_i),
        .pi1_rdy_o (pi1_rdy_o),
        .intsrc_i  (intsrc_i),
        .intrqst_o (intrqst_o),
        .intrdy_i  (intrdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [ARCHBITSZ-1:0] ackArg(input int p);
        return (ARCHBITSZ'(p) << 1) | ARCHBITSZ'(1);
    endfunction

    function automatic logic [ARCHBITSZ-1:0] trigArg(input int s);
        return ARCHBITSZ'(s) << 1;
    endfunction

    // Every accepted op yields exactly one result on the following cycle.
    always @(posedge clk_i) opSeen <= (pi1_op_i != OP_NOOP) && !rst_i;

    always @(negedge clk_i) begin
        if (opSeen) begin
            checkOutput("respQueued", qResp.size() > 0, 1);
            if (qResp.size() > 0) checkOutput("pi1Resp", pi1_data_o, qResp.pop_front());
        end
        if (intrqst_o != 0) checkOutput("reqOneHot", $countones(intrqst_o), 1);
        if (intrqst_o != 0 && prevReq == 0) begin
            checkOutput("reqExpected", qDeliv.size() > 0, 1);
            if (qDeliv.size() > 0) checkOutput("reqTarget", intrqst_o, 64'(1) << qDeliv.pop_front());
        end
        prevReq = intrqst_o;
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [ARCHBITSZ-1:0] data,
                                 input logic [ARCHBITSZ-1:0] expected);
        @(negedge clk_i);
        pi1_op_i   = op;
        pi1_data_i = data;
        qResp.push_back(expected);
        @(negedge clk_i);
        pi1_op_i = OP_NOOP;
    endtask

    task automatic applyReset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        modelRr = 0;
    endtask

    task automatic expectDeliv();
        qDeliv.push_back(modelRr);
        modelRr = (modelRr + 1) % DSTCOUNT;
    endtask

    // Emulated PU: wait for a request, take it after a short delay, then ACK its id.
    task automatic serveOne(input int expSrc);
        int n;
        int d;
        n = 0;
        while (intrqst_o == 0 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("reqArrived", intrqst_o != 0, 1);
        if (intrqst_o == 0) return;
        d = 0;
        for (int i = 0; i < DSTCOUNT; i++) if (intrqst_o[i]) d = i;
        repeat ($urandom_range(2, 5)) @(negedge clk_i);
        intrdy_i[d] = 1'b0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (intrqst_o != 0 && n < 10);
        checkOutput("reqDropped", intrqst_o, 0);
        intrdy_i[d] = 1'b1;
        applyStimulus(OP_RW, ackArg(d), ARCHBITSZ'(expSrc));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int found;
        int n;
        int hi;
        int seen;
        int doTrig;
        int s;
        logic [SRCCOUNT-1:0] mask;
        logic [SRCCOUNT-1:0] setMask;

        rst_i = 1'b1;
        pi1_op_i = OP_NOOP;
        pi1_addr_i = '0;
        pi1_data_i = '0;
        pi1_sel_i = '0;
        intsrc_i = '0;
        intrdy_i = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("rstReq", intrqst_o, 0);
        checkOutput("rstRdy", pi1_rdy_o, 1);
        checkOutput("rstData", pi1_data_o, ALLONES);
        rst_i = 1'b0;

        applyStimulus(OP_WR, 32'h5, ALLONES);
        applyStimulus(OP_RD, 32'h0, ALLONES);
        applyStimulus(OP_RW, ackArg(0), ALLONES);
        applyStimulus(OP_RW, ackArg(DSTCOUNT), ALLONES);

        // Single source delivered to PU0, then ACK consumes the id.
        intrdy_i = 2'b11;
        expectDeliv();
        @(negedge clk_i);
        intsrc_i[1] = 1'b1;
        found = 0;
        for (int i = 0; i < 3 && found == 0; i++) begin
            @(negedge clk_i);
            if (intrqst_o == 2'b01) found = 1;
        end
        checkOutput("reqWithin3", found, 1);
        intrdy_i[0] = 1'b0;
        @(negedge clk_i);
        checkOutput("reqDropOnAccept", intrqst_o, 0);
        intrdy_i[0] = 1'b1;
        intsrc_i[1] = 1'b0;
        applyStimulus(OP_RW, ackArg(0), 1);
        applyStimulus(OP_RW, ackArg(0), ALLONES);

        // Two simultaneous sources go out lowest first, to alternating PUs.
        applyReset();
        intrdy_i = 2'b11;
        expectDeliv();
        expectDeliv();
        @(negedge clk_i);
        intsrc_i[1:0] = 2'b11;
        @(negedge clk_i);
        intsrc_i = '0;
        serveOne(0);
        serveOne(1);

        // Ignored request times out after ACKTIMEOUT cycles, then moves to PU1.
        applyReset();
        intrdy_i = 2'b01;
        qDeliv.push_back(0);
        qDeliv.push_back(1);
        modelRr = 0;
        @(negedge clk_i);
        intsrc_i[2] = 1'b1;
        @(negedge clk_i);
        intsrc_i[2] = 1'b0;
        n = 0;
        while (intrqst_o[0] == 1'b0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("timeoutStart", intrqst_o[0], 1);
        hi = 0;
        while (intrqst_o[0] == 1'b1 && hi < 4*ACKTIMEOUT) begin
            hi++;
            @(negedge clk_i);
        end
        checkOutput("timeoutWidth", hi, ACKTIMEOUT);
        intrdy_i = 2'b11;
        serveOne(2);

        // TRIGGER in range delivers; out of range does nothing.
        applyReset();
        intrdy_i = 2'b11;
        expectDeliv();
        applyStimulus(OP_RW, trigArg(1), 1);
        serveOne(1);
        applyStimulus(OP_RW, trigArg(SRCCOUNT), ALLONES);
        seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (intrqst_o != 0) seen = 1;
        end
        checkOutput("trigOutOfRangeQuiet", seen, 0);

        // Reset during a request to PU1 drops it and forgets the pending source.
        applyReset();
        intrdy_i = 2'b10;
        qDeliv.push_back(1);
        @(negedge clk_i);
        intsrc_i[0] = 1'b1;
        n = 0;
        while (intrqst_o[1] == 1'b0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("rstReqStart", intrqst_o[1], 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rstReqDrop", intrqst_o, 0);
        rst_i = 1'b0;
        modelRr = 0;
        intrdy_i = 2'b11;
        seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (intrqst_o != 0) seen = 1;
        end
        checkOutput("rstNoPending", seen, 0);
        applyStimulus(OP_RW, ackArg(1), ALLONES);
        intsrc_i[0] = 1'b0;

        // Repeated edges before acceptance collapse into a single delivery.
        applyReset();
        intrdy_i = 2'b11;
        expectDeliv();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            intsrc_i[0] = 1'b1;
            @(negedge clk_i);
            intsrc_i[0] = 1'b0;
        end
        serveOne(0);
        applyStimulus(OP_RW, ackArg(0), ALLONES);
        seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (intrqst_o != 0) seen = 1;
        end
        checkOutput("singleDelivery", seen, 0);

        // Random batches: edges plus an optional TRIGGER in the same cycle.
        applyReset();
        intrdy_i = 2'b11;
        for (int b = 0; b < 25; b++) begin
            mask = SRCCOUNT'($urandom_range(1, (1 << SRCCOUNT) - 1));
            doTrig = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, SRCCOUNT));
            setMask = mask;
            if (doTrig == 1 && s < SRCCOUNT) setMask[s] = 1'b1;
            for (int i = 0; i < SRCCOUNT; i++) if (setMask[i]) expectDeliv();
            @(negedge clk_i);
            intsrc_i = mask;
            if (doTrig == 1) begin
                pi1_op_i = OP_RW;
                pi1_data_i = trigArg(s);
                qResp.push_back((s < SRCCOUNT) ? ARCHBITSZ'(s) : ALLONES);
            end
            @(negedge clk_i);
            intsrc_i = '0;
            pi1_op_i = OP_NOOP;
            for (int i = 0; i < SRCCOUNT; i++) if (setMask[i]) serveOne(i);
        end

        repeat (5) @(negedge clk_i);
        checkOutput("respQueueEmpty", qResp.size(), 0);
        checkOutput("delivQueueEmpty", qDeliv.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
